reg_shifter: RTL and testbench
==============================

REG_SHIFTER -- requirements
Module: reg_shifter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data register width (minimum 2).
REQ-002 Parameter AW, default $clog2(WIDTH), SHALL set the shift-amount width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be the command strobe, sampled only in IDLE.
REQ-006 op  input  3  SHALL be the command code: 000 NOP, 001 LOAD, 010 SRL, 011 SLL, 100 SRA, 101 ROR, 110 ROL, 111 CLR.
REQ-007 amount  input  AW  SHALL be the number of single-bit positions to shift or rotate.
REQ-008 in  input  WIDTH  SHALL be the LOAD data.
REQ-009 saida  output  WIDTH  SHALL be the registered data value.
REQ-010 carry  output  1  SHALL be the last bit shifted or rotated out.
REQ-011 busy  output  1  SHALL be high while a multi-cycle shift is in progress.
REQ-012 done  output  1  SHALL be a one-cycle pulse marking command completion.
REQ-013 zero  output  1  SHALL be combinationally high when saida == 0.

Function
REQ-014 FSM states IDLE, SHIFT and DONE SHALL be the only states.
REQ-015 IDLE with start=1: the command SHALL be accepted on that edge; op and amount SHALL be captured.
REQ-016 LOAD SHALL write in to saida and clear carry on the accept edge, then go to DONE.
REQ-017 CLR SHALL zero saida and carry on the accept edge, then go to DONE.
REQ-018 NOP SHALL change nothing and go to DONE.
REQ-019 Shift ops with amount=0 SHALL go straight to DONE with saida and carry unchanged.
REQ-020 Shift ops with amount>0 SHALL enter SHIFT, load a down-counter with amount and move one position per cycle.
REQ-021 Each step: SRL shifts in 0 at the MSB; SLL shifts in 0 at the LSB; SRA replicates the MSB; ROR/ROL wrap the exiting bit; carry takes the exiting bit.
REQ-022 SHIFT SHALL last exactly amount cycles; after the final step the FSM SHALL go to DONE.
REQ-023 busy SHALL be high exactly in SHIFT; done SHALL be high exactly in DONE; DONE SHALL return to IDLE after one cycle.
REQ-024 Total latency from the accept edge to done high SHALL be amount+1 cycles for shifts and 1 cycle otherwise.
REQ-025 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-026 op and in changes after acceptance SHALL NOT affect the command in progress.
REQ-027 saida SHALL hold its value in IDLE without a command.

Reset
REQ-028 rst low SHALL immediately force IDLE, saida=0, carry=0, busy=0, done=0 and counter=0, including mid-SHIFT.
REQ-029 The first command SHALL be accepted on the first rising edge with rst high and start high.

Structure
REQ-030 Package reg_shifter_pkg SHALL hold the op-code constants and the FSM state encoding.
REQ-031 Combinational sub-module shift_step SHALL compute one single-position step (next data, exiting bit) from op and the current value.

Verification (WIDTH=8)
REQ-032 LOAD 0xB5, then SRA amount=3 -> busy for 3 cycles, done on cycle 4, saida=0xF6, carry=1.
REQ-033 LOAD 0x81, then ROL amount=1 -> saida=0x03, carry=1; ROR amount=1 -> saida=0x81, carry=1.
REQ-034 LOAD 0x01, SLL amount=7 -> saida=0x80, carry=0, zero=0; SRL amount=7 -> saida=0x01; CLR -> saida=0x00, zero=1.
REQ-035 SRL amount=0 on 0x5A -> done one cycle after accept, busy never high, saida=0x5A, carry unchanged.
REQ-036 start with op=LOAD, in=0xFF pulsed during SHIFT -> ignored; final result matches the original shift.
REQ-037 rst driven low mid-SHIFT with no clock edge -> saida=0, carry=0, busy=0 at once; after release, LOAD 0x3C completes normally.

Source files
------------

// File: rtl/reg_shifter_pkg.sv
// Shared definitions for the register shifter: command codes and FSM state encoding.
package reg_shifter_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_LOAD = 3'b001,
      OP_SRL  = 3'b010,
      OP_SLL  = 3'b011,
      OP_SRA  = 3'b100,
      OP_ROR  = 3'b101,
      OP_ROL  = 3'b110,
      OP_CLR  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   // True for the five ops that move bits one position per SHIFT cycle.
   function automatic logic is_shift_op(input op_e op);
      return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA) ||
             (op == OP_ROR) || (op == OP_ROL);
   endfunction

endpackage

// File: rtl/reg_shifter_shift_step.sv
// One single-position shift/rotate step: next data word and the bit that leaves it.
module shift_step
   import reg_shifter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             bit_o
);

   // Select the shifted word and the exiting bit for the captured op.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      data_o = data_i;
      bit_o  = 1'b0;
      case (op)
         OP_SRL: begin
            data_o = {1'b0, data_i[WIDTH-1:1]};
            bit_o  = data_i[0];
         end
         OP_SLL: begin
            data_o = {data_i[WIDTH-2:0], 1'b0};
            bit_o  = data_i[WIDTH-1];
         end
         OP_SRA: begin
            data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            bit_o  = data_i[0];
         end
         OP_ROR: begin
            data_o = {data_i[0], data_i[WIDTH-1:1]};
            bit_o  = data_i[0];
         end
         OP_ROL: begin
            data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
            bit_o  = data_i[WIDTH-1];
         end
         default: begin
            data_o = data_i;
            bit_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/reg_shifter.sv
// Command-driven data register with multi-cycle shift/rotate, one position per clock.
module reg_shifter
   import reg_shifter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    amount,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] saida,
   output logic             carry,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] step_data;
   logic             step_bit;
   op_e              op_in;

   assign op_in = op_e'(op);

   // The step always works from the op captured at accept, so later op changes are harmless.
   shift_step #(.WIDTH(WIDTH)) u_step (
      .op     (op_q),
      .data_i (data_q),
      .data_o (step_data),
      .bit_o  (step_bit)
   );

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      carry_d = carry_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = op_in;
               state_d = ST_DONE;
               case (op_in)
                  OP_LOAD: begin
                     data_d  = in;
                     carry_d = 1'b0;
                  end
                  OP_CLR: begin
                     data_d  = '0;
                     carry_d = 1'b0;
                  end
                  default: begin
                     // Zero-length shifts finish immediately with data and carry untouched.
                     if (is_shift_op(op_in) && (amount != '0)) begin
                        cnt_d   = amount;
                        state_d = ST_SHIFT;
                     end
                  end
               endcase
            end
         end
         ST_SHIFT: begin
            data_d  = step_data;
            carry_d = step_bit;
            cnt_d   = cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Status flags are derived from the next state so they register alongside it.
      busy_d = (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers; reset acts immediately, even mid-shift.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         cnt_q   <= '0;
         data_q  <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign saida = data_q;
   assign carry = carry_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign zero  = (data_q == '0);

endmodule

// File: tb/tb_reg_shifter.sv
// Directed self-checking bench for reg_shifter at WIDTH=8.
module tb_reg_shifter;

   localparam logic [2:0] C_NOP  = 3'b000;
   localparam logic [2:0] C_LOAD = 3'b001;
   localparam logic [2:0] C_SRL  = 3'b010;
   localparam logic [2:0] C_SLL  = 3'b011;
   localparam logic [2:0] C_SRA  = 3'b100;
   localparam logic [2:0] C_ROR  = 3'b101;
   localparam logic [2:0] C_ROL  = 3'b110;
   localparam logic [2:0] C_CLR  = 3'b111;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] op;
   logic [2:0] amount;
   logic [7:0] din;
   logic [7:0] saida;
   logic       carry, busy, done, zero;

   int checks   = 0;
   int failures = 0;
   int lat, nbusy;

   reg_shifter #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .amount (amount),
      .in     (din),
      .saida  (saida),
      .carry  (carry),
      .busy   (busy),
      .done   (done),
      .zero   (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Wait (bounded) for done, counting cycles from the accept edge and busy cycles seen.
   task automatic wait_done(output int l, output int nb);
      logic seen = 1'b0;
      l  = 0;
      nb = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         l++;
         if (busy) nb++;
         if (done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'd1);
   endtask

   // Issue one command, then scramble op/in/amount to show the capture holds.
   task automatic run_cmd(input logic [2:0] c_op, input logic [2:0] c_amt,
                          input logic [7:0] c_in, output int l, output int nb);
      @(negedge clk);
      start  = 1'b1;
      op     = c_op;
      amount = c_amt;
      din    = c_in;
      @(posedge clk);
      #1;
      start  = 1'b0;
      op     = C_CLR;
      amount = ~c_amt;
      din    = 8'hA5;
      wait_done(l, nb);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; start = 1'b0; op = C_NOP; amount = '0; din = '0;
      #12;
      check("rst_saida", 32'(saida), 32'h00);
      check("rst_carry", 32'(carry), 32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_zero",  32'(zero),  32'd1);
      @(negedge clk);
      rst = 1'b1;

      // SRA on a negative value
      run_cmd(C_LOAD, 3'd0, 8'hB5, lat, nbusy);
      check("load_lat",   32'(lat),   32'd1);
      check("load_saida", 32'(saida), 32'hB5);
      check("load_carry", 32'(carry), 32'd0);
      check("load_zero",  32'(zero),  32'd0);
      run_cmd(C_SRA, 3'd3, 8'h00, lat, nbusy);
      check("sra_lat",   32'(lat),   32'd4);
      check("sra_busy",  32'(nbusy), 32'd3);
      check("sra_saida", 32'(saida), 32'hF6);
      check("sra_carry", 32'(carry), 32'd1);

      // rotates wrap the exiting bit
      run_cmd(C_LOAD, 3'd0, 8'h81, lat, nbusy);
      run_cmd(C_ROL, 3'd1, 8'h00, lat, nbusy);
      check("rol_lat",   32'(lat),   32'd2);
      check("rol_saida", 32'(saida), 32'h03);
      check("rol_carry", 32'(carry), 32'd1);
      run_cmd(C_ROR, 3'd1, 8'h00, lat, nbusy);
      check("ror_saida", 32'(saida), 32'h81);
      check("ror_carry", 32'(carry), 32'd1);

      // maximum-length logical shifts and CLR
      run_cmd(C_LOAD, 3'd0, 8'h01, lat, nbusy);
      run_cmd(C_SLL, 3'd7, 8'h00, lat, nbusy);
      check("sll_lat",   32'(lat),   32'd8);
      check("sll_busy",  32'(nbusy), 32'd7);
      check("sll_saida", 32'(saida), 32'h80);
      check("sll_carry", 32'(carry), 32'd0);
      check("sll_zero",  32'(zero),  32'd0);
      run_cmd(C_SRL, 3'd7, 8'h00, lat, nbusy);
      check("srl_saida", 32'(saida), 32'h01);
      check("srl_carry", 32'(carry), 32'd0);
      run_cmd(C_CLR, 3'd0, 8'h00, lat, nbusy);
      check("clr_lat",   32'(lat),   32'd1);
      check("clr_saida", 32'(saida), 32'h00);
      check("clr_zero",  32'(zero),  32'd1);

      // zero-length shift, NOP and idle hold keep data and a set carry
      run_cmd(C_LOAD, 3'd0, 8'hB5, lat, nbusy);
      run_cmd(C_SRL, 3'd1, 8'h00, lat, nbusy);
      check("srl1_saida", 32'(saida), 32'h5A);
      check("srl1_carry", 32'(carry), 32'd1);
      run_cmd(C_SRL, 3'd0, 8'h00, lat, nbusy);
      check("srl0_lat",   32'(lat),   32'd1);
      check("srl0_busy",  32'(nbusy), 32'd0);
      check("srl0_saida", 32'(saida), 32'h5A);
      check("srl0_carry", 32'(carry), 32'd1);
      run_cmd(C_NOP, 3'd5, 8'hFF, lat, nbusy);
      check("nop_lat",   32'(lat),   32'd1);
      check("nop_saida", 32'(saida), 32'h5A);
      check("nop_carry", 32'(carry), 32'd1);
      repeat (3) @(negedge clk);
      check("hold_saida", 32'(saida), 32'h5A);

      // start ignored in SHIFT and in DONE
      run_cmd(C_LOAD, 3'd0, 8'hB5, lat, nbusy);
      @(negedge clk);
      start = 1'b1; op = C_ROR; amount = 3'd3; din = 8'h00;
      @(posedge clk);
      #1;
      op = C_LOAD; din = 8'hFF;
      lat = 0;
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 2) start = 1'b0;
            if (done) seen = 1'b1;
         end
         check("ign_done_seen", 32'(seen), 32'd1);
      end
      check("ign_lat", 32'(lat), 32'd4);
      start = 1'b1; op = C_LOAD; din = 8'hFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("ign_saida", 32'(saida), 32'hB6);
      check("ign_carry", 32'(carry), 32'd1);
      check("ign_busy",  32'(busy),  32'd0);
      check("ign_done",  32'(done),  32'd0);

      // asynchronous reset in the middle of a shift
      run_cmd(C_LOAD, 3'd0, 8'hB5, lat, nbusy);
      @(negedge clk);
      start = 1'b1; op = C_SLL; amount = 3'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_saida", 32'(saida), 32'h00);
      check("arst_carry", 32'(carry), 32'd0);
      check("arst_busy",  32'(busy),  32'd0);
      check("arst_done",  32'(done),  32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_busy", 32'(busy), 32'd0);
      run_cmd(C_LOAD, 3'd0, 8'h3C, lat, nbusy);
      check("post_lat",   32'(lat),   32'd1);
      check("post_saida", 32'(saida), 32'h3C);
      check("post_carry", 32'(carry), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
